// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue: FIFO of {pc, instr} pairs with pre-split opcode
module fetch_queue #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_instr,
    output logic [6:0]                 out_opcode,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_next;

    logic push;
    logic pop;

    // Ready/valid depend only on registered count, so no in->out combinational path.
    assign in_ready   = (count_q != CW'(DEPTH));
    assign out_valid  = (count_q != '0);
    assign push       = in_valid & in_ready;
    assign pop        = out_valid & out_ready;

    assign out_pc     = pc_mem[rd_ptr];
    assign out_instr  = instr_mem[rd_ptr];
    assign out_opcode = out_instr[6:0];
    assign count      = count_q;

    always_comb begin
        count_next = count_q;
        if (push && !pop) begin
            count_next = count_q + CW'(1);
        end else if (pop && !push) begin
            count_next = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count_q <= count_next;
        end
    end

    // Storage is not reset; a flushed or reset-cycle push is simply never written.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && push) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [6:0]  out_opcode;
    logic [3:0]  count;

    int total = 0;
    int bad   = 0;

    fetch_queue #(.DEPTH(8), .XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_instr   (in_instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_instr  (out_instr),
        .out_opcode (out_opcode),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [31:0] instr);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        out_ready = 1'b0;
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // three pushes, decode stalled
        push_one(32'h00, 32'h0000_0013);
        push_one(32'h04, 32'h00A0_0093);
        push_one(32'h08, 32'h0000_006F);
        check("three_count", 32'(count), 32'd3);
        check("three_out_valid", 32'(out_valid), 32'd1);
        check("three_out_pc", out_pc, 32'h00);
        check("three_opcode", 32'(out_opcode), 32'h13);
        check("three_instr", out_instr, 32'h0000_0013);

        // fill to DEPTH
        for (int i = 3; i < 8; i++) begin
            push_one(32'(4 * i), 32'h0000_0013);
        end
        check("full_count", 32'(count), 32'd8);
        check("full_in_ready", 32'(in_ready), 32'd0);
        push_one(32'h99, 32'h0000_0013);
        check("ninth_count", 32'(count), 32'd8);

        // pop while full with in_valid held: no push-on-pop
        in_valid  = 1'b1;
        in_pc     = 32'h99;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("pop_full_count", 32'(count), 32'd7);
        check("pop_full_in_ready", 32'(in_ready), 32'd1);

        // drain, order check
        out_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            check("drain_pc", out_pc, 32'(4 * i));
            step();
        end
        out_ready = 1'b0;
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_count", 32'(count), 32'd0);

        // streaming across pointer wrap
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_instr  = 32'h0000_0013;
        in_pc     = 32'h1000;
        check("stream_pre_valid", 32'(out_valid), 32'd0);
        step();
        check("stream_first_valid", 32'(out_valid), 32'd1);
        for (int k = 1; k < 24; k++) begin
            in_pc = 32'h1000 + 32'(4 * k);
            check("stream_pc", out_pc, 32'h1000 + 32'(4 * (k - 1)));
            check("stream_count", 32'(count), 32'd1);
            step();
        end
        in_valid = 1'b0;
        check("stream_last_pc", out_pc, 32'h1000 + 32'(4 * 23));
        step();
        out_ready = 1'b0;
        check("stream_end_count", 32'(count), 32'd0);

        // flush with simultaneous push and pop
        for (int i = 0; i < 5; i++) begin
            push_one(32'h200 + 32'(4 * i), 32'h0000_0013);
        end
        check("preflush_count", 32'(count), 32'd5);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h2FC;
        out_ready = 1'b1;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        push_one(32'h100, 32'h0000_0013);
        check("postflush_pc", out_pc, 32'h100);
        check("postflush_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("postflush_drain", 32'(out_valid), 32'd0);

        // reset mid-operation
        for (int i = 0; i < 3; i++) begin
            push_one(32'h300 + 32'(4 * i), 32'h0000_0013);
        end
        check("prerst_count", 32'(count), 32'd3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        push_one(32'h40, 32'h0000_0013);
        check("postrst_pc", out_pc, 32'h40);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // branch opcode at head
        push_one(32'h50, 32'h0020_8663);
        check("beq_opcode", 32'(out_opcode), 32'h63);
        check("beq_pc", out_pc, 32'h50);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("beq_pop_valid", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction buffer between fetch and the opcode control decoder. Decouples fetch from decode/dispatch stalls.
- Stores {pc, instr} pairs in FIFO order and presents the head entry to decode with its opcode field pre-split.
- Discards all buffered entries on a pipeline flush, such as a branch mispredict or JAL redirect.

Parameters:
- DEPTH, 8, number of entries; must be a power of two and at least 2.
- XLEN, 32, width of pc and instr.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; synchronous, active-low
- flush  in  1  discard every entry on this edge
- in_valid  in  1  fetch presents an entry
- in_ready  out  1  queue can accept an entry
- in_pc  in  XLEN  pc of the fetched instruction
- in_instr  in  XLEN  fetched instruction word
- out_valid  out  1  head entry is valid
- out_ready  in  1  decode consumes the head entry
- out_pc  out  XLEN  pc of the head entry
- out_instr  out  XLEN  instruction word of the head entry
- out_opcode  out  7  out_instr[6:0], feeds the decoder's opcode input
- count  out  $clog2(DEPTH)+1  number of occupied entries

Behaviour:
- Storage: circular buffer.
  - Read pointer rd_ptr and write pointer wr_ptr, each $clog2(DEPTH) bits, plus a count register.
  - Pointers wrap from DEPTH-1 to 0 by natural overflow.
- Handshake:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Transfers occur on the rising edge where the condition holds.
  - Once in_valid is asserted, fetch holds in_pc and in_instr stable until the push happens.
- Derived outputs, combinational from registers only (no input-to-output paths):
  - in_ready = (count != DEPTH)
  - out_valid = (count != 0)
  - out_pc and out_instr = entry at rd_ptr
  - out_opcode = out_instr[6:0]
- Latency: an entry pushed on edge N is visible on the out_* ports after edge N. There is no bypass from in_* to out_*, so the minimum latency is 1 cycle.
- Count update:
  - count_next = count + push - pop.
  - Push and pop in the same cycle leave count unchanged; both pointers advance.
- Full boundary: when count == DEPTH, in_ready = 0, even if a pop happens in that same cycle. There is no push-on-pop when full, which avoids a ready-to-ready combinational path.
- Empty boundary: when count == 0, out_valid = 0. out_ready is ignored. out_pc and out_instr hold stale data that must not be interpreted.
- Flush:
  - When flush = 1 on an edge: rd_ptr = 0, wr_ptr = 0, count = 0.
  - Any push or pop in that cycle is discarded; the push is neither written nor counted.
  - On the following cycle, out_valid = 0 and in_ready = 1.
  - Flush has priority over push and pop.
- Reset:
  - When rst_n = 0 on an edge: rd_ptr = 0, wr_ptr = 0, count = 0.
  - Reset has priority over flush.
  - After reset: out_valid = 0, in_ready = 1, count = 0.
  - Entry storage need not be reset; out_pc, out_instr and out_opcode are don't-care while out_valid = 0.
- Reset mid-operation: asserting rst_n = 0 while the queue is partially full discards all entries, exactly like flush.
- Ordering: entries leave in strict push order. Data is never duplicated or dropped except by flush or reset.
- Overflow and underflow are impossible by construction. An assertion fires if count ever exceeds DEPTH.

Test Plan:
- Reset, then push pc = 0x00, 0x04, 0x08 with instr = 0x00000013, 0x00A00093, 0x0000006F while out_ready = 0 -> count = 3, out_valid = 1, out_pc = 0x00, out_opcode = 7'b0010011.
- DEPTH = 8: push 8 entries with no pops -> in_ready = 0 and count = 8 after the 8th push. A 9th in_valid is not accepted. Popping once -> in_ready = 1 the next cycle.
- Hold in_valid = 1 and out_ready = 1 continuously from empty -> out_valid rises 1 cycle after the first push. Then one entry per cycle, count stays at 1, and pcs emerge in order across pointer wrap (≥ 20 entries).
- Queue holds 5 entries; assert flush together with in_valid = 1 and out_ready = 1 -> next cycle count = 0, out_valid = 0, and the flushed-cycle entry never appears. A subsequent push of pc = 0x100 emerges first.
- Queue holds 3 entries; drive rst_n = 0 for one edge -> count = 0, out_valid = 0, in_ready = 1. Pushing pc = 0x40 afterwards makes out_pc = 0x40.
- Push an entry with instr = 0x00208663 (beq) -> out_opcode = 7'b1100011 while it sits at the head. Pop it -> out_valid = 0.
